// File: rtl/vend_pkg.sv
// vend_pkg: shared coin codes, FSM state encodings and credit helpers for the vending port arbiter
package vend_pkg;
  localparam int CREDIT_W = 3;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_INV  = 2'b11;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_COLLECT   = 2'd1;
  localparam logic [1:0] S_VEND_WAIT = 2'd2;
  localparam logic [1:0] S_REFUND    = 2'd3;
  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] c);
    return c == COIN_5 ? CREDIT_W'(1) : c == COIN_10 ? CREDIT_W'(2) : CREDIT_W'(0);
  endfunction
endpackage

// File: rtl/vend_port_arbiter_if.sv
// vend_port_arbiter_if: customer panel and core-side signals of the port arbiter
interface vend_port_arbiter_if #(parameter int N_PORTS = 4);
  localparam int W = $clog2(N_PORTS);
  logic [N_PORTS-1:0]   port_req;
  logic [2*N_PORTS-1:0] port_coin;
  logic [N_PORTS-1:0]   grant;
  logic                 busy;
  logic [1:0]           vm_in;
  logic                 vm_clr;
  logic                 vm_out;
  logic [1:0]           vm_change;
  logic [N_PORTS-1:0]   port_vend;
  logic [2*N_PORTS-1:0] port_change;
  logic [N_PORTS-1:0]   port_reject;
  logic                 refund_valid;
  logic [W-1:0]         refund_port;
  logic [vend_pkg::CREDIT_W-1:0] refund_amt;
  logic                 fault;
  modport slave (
    input  port_req, port_coin, vm_out, vm_change,
    output grant, busy, vm_in, vm_clr, port_vend, port_change, port_reject,
           refund_valid, refund_port, refund_amt, fault
  );
  modport master (
    output port_req, port_coin, vm_out, vm_change,
    input  grant, busy, vm_in, vm_clr, port_vend, port_change, port_reject,
           refund_valid, refund_port, refund_amt, fault
  );
endinterface

// File: rtl/vend_rr_arbiter.sv
// vend_rr_arbiter: combinational round-robin pick of the first requester at or after the pointer
module vend_rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] win_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [W-1:0] j;
  // scan offsets from farthest to nearest so the nearest requester is written last and wins
  always_comb begin
    j = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        idx_o = j;
        any_o = 1'b1;
      end
    end
  end
  assign win_o = any_o ? N'(1) << idx_o : '0;
endmodule

// File: rtl/vend_port_arbiter.sv
// vend_port_arbiter: shares one vending core among N_PORTS coin panels with refund and fault handling
module vend_port_arbiter
  import vend_pkg::*;
#(
  parameter int N_PORTS     = 4,
  parameter int TIMEOUT     = 64,
  parameter int VEND_WAIT   = 8,
  parameter int PRICE_UNITS = 3
) (
  input logic clk,
  input logic rst_n,
  vend_port_arbiter_if.slave bus
);
  localparam int W  = $clog2(N_PORTS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int VW = $clog2(VEND_WAIT + 1);
  logic [1:0]           state_q, state_d;
  logic [N_PORTS-1:0]   grant_q, grant_d;
  logic [W-1:0]         g_q, g_d, ptr_q, ptr_d, nxt;
  logic [CREDIT_W-1:0]  credit_q, credit_d, units, credit_sat;
  logic [CREDIT_W:0]    sum;
  logic [TW-1:0]        timer_q, timer_d;
  logic [VW-1:0]        wait_q, wait_d;
  logic [1:0]           vm_in_q, vm_in_d, own_coin;
  logic [N_PORTS-1:0]   port_vend_q, port_vend_d, port_reject_q, port_reject_d;
  logic [2*N_PORTS-1:0] port_change_q, port_change_d;
  logic                 fault_q, fault_d, own_req, accept;
  logic [N_PORTS-1:0]   win;
  logic [W-1:0]         win_idx;
  logic                 any;
  vend_rr_arbiter #(.N(N_PORTS), .W(W)) u_rr (
    .req_i (bus.port_req),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (win_idx),
    .any_o (any)
  );
  assign own_coin   = bus.port_coin[{g_q, 1'b0} +: 2];
  assign own_req    = bus.port_req[g_q];
  assign units      = coin_units(own_coin);
  assign accept     = state_q == S_COLLECT && own_req && units != '0;
  assign sum        = {1'b0, credit_q} + {1'b0, units};
  assign credit_sat = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
  assign nxt        = g_q == W'(N_PORTS - 1) ? '0 : g_q + 1'b1;
  assign vm_in_d    = accept ? own_coin : COIN_NONE;
  // any coin that is not forwarded to the core is flagged back to its own panel
  always_comb begin
    port_reject_d = '0;
    for (int i = 0; i < N_PORTS; i++)
      port_reject_d[i] = bus.port_coin[2*i +: 2] != COIN_NONE && !(accept && grant_q[i]);
  end
  // transaction FSM: grant, collect credit, wait for the core, then vend or refund
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    g_d           = g_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    timer_d       = timer_q;
    wait_d        = wait_q;
    port_vend_d   = '0;
    port_change_d = '0;
    fault_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_q != '0) grant_d = '0;
        else if (any) begin
          grant_d  = win;
          g_d      = win_idx;
          credit_d = '0;
          timer_d  = '0;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        credit_d = accept ? credit_sat : credit_q;
        timer_d  = accept || credit_q == '0 ? '0 : timer_q + 1'b1;
        if (!own_req) begin
          state_d = credit_q == '0 ? S_IDLE : S_REFUND;
          grant_d = credit_q == '0 ? '0 : grant_q;
        end else if (credit_d >= CREDIT_W'(PRICE_UNITS)) begin
          wait_d  = '0;
          state_d = S_VEND_WAIT;
        end else if (!accept && credit_q != '0 && timer_q == TW'(TIMEOUT - 1))
          state_d = S_REFUND;
      end
      S_VEND_WAIT: begin
        if (bus.vm_out) begin
          port_vend_d                   = grant_q;
          port_change_d[{g_q, 1'b0} +: 2] = bus.vm_change;
          credit_d                      = '0;
          ptr_d                         = nxt;
          state_d                       = S_IDLE;
        end else if (wait_q == VW'(VEND_WAIT - 1)) begin
          fault_d = 1'b1;
          state_d = S_REFUND;
        end else wait_d = wait_q + 1'b1;
      end
      default: begin
        grant_d  = '0;
        credit_d = '0;
        ptr_d    = nxt;
        state_d  = S_IDLE;
      end
    endcase
  end
  // state and registered outputs; reset drops any in-flight credit without a refund
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      g_q           <= '0;
      ptr_q         <= '0;
      credit_q      <= '0;
      timer_q       <= '0;
      wait_q        <= '0;
      vm_in_q       <= COIN_NONE;
      port_vend_q   <= '0;
      port_change_q <= '0;
      port_reject_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      g_q           <= g_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      wait_q        <= wait_d;
      vm_in_q       <= vm_in_d;
      port_vend_q   <= port_vend_d;
      port_change_q <= port_change_d;
      port_reject_q <= port_reject_d;
      fault_q       <= fault_d;
    end
  end
  assign bus.grant        = grant_q;
  assign bus.busy         = |grant_q;
  assign bus.vm_in        = vm_in_q;
  assign bus.vm_clr       = state_q == S_REFUND;
  assign bus.refund_valid = state_q == S_REFUND;
  assign bus.refund_port  = state_q == S_REFUND ? g_q : '0;
  assign bus.refund_amt   = state_q == S_REFUND ? credit_q : '0;
  assign bus.port_vend    = port_vend_q;
  assign bus.port_change  = port_change_q;
  assign bus.port_reject  = port_reject_q;
  assign bus.fault        = fault_q;
endmodule

// File: doc/vend_port_arbiter.md
Name: vend_port_arbiter

Overview:
- Shares one vending_machine core among N_PORTS customer coin panels.
- Grants exactly one port per transaction (round-robin) and forwards that port's coins to the core.
- Routes the core's vend/change result back to the granted port.
- Refunds accumulated credit on customer abandon, inactivity timeout or core no-response, and clears the core before the next grant.

Parameters:
- N_PORTS, 4, number of customer panels (2..8).
- TIMEOUT, 64, idle cycles in COLLECT before refund.
- VEND_WAIT, 8, max cycles to wait for core vend after price reached.
- PRICE_UNITS, 3, item price in ₹5 units (₹15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- port_req  in  N_PORTS  customer present/requesting, level.
- port_coin  in  2*N_PORTS  per-port coin code: 00 none, 01 ₹5, 10 ₹10, 11 invalid.
- grant  out  N_PORTS  one-hot, current owner.
- busy  out  1  transaction in progress.
- vm_in  out  2  coin code to core.
- vm_clr  out  1  one-cycle clear pulse to core (active-high).
- vm_out  in  1  core vend pulse.
- vm_change  in  2  core change code, valid with vm_out.
- port_vend  out  N_PORTS  one-cycle vend pulse to owner.
- port_change  out  2*N_PORTS  change code to owner, valid with port_vend.
- port_reject  out  N_PORTS  one-cycle pulse: coin ignored.
- refund_valid  out  1  one-cycle refund pulse.
- refund_port  out  $clog2(N_PORTS)  refunded port index.
- refund_amt  out  3  refund in ₹5 units.
- fault  out  1  one-cycle pulse: core failed to vend within VEND_WAIT.

Behaviour:
- Reset: state IDLE, all outputs 0, credit 0, rr pointer 0, timers 0. Async assert; deassert takes effect at the next clk.
- IDLE:
  - If any port_req is high, pick the first requesting port at or after the rr pointer (wrapping).
  - grant and busy are registered: high the next cycle. Go to COLLECT.
- COLLECT:
  - Granted port coin 01/10 at cycle t: vm_in equals that code at t+1; credit += 1 or 2 at t+1; timer clears.
  - Any other cycle: vm_in=00.
  - Coin 11: not forwarded; port_reject pulses for that port.
  - Coins from non-granted ports: port_reject pulses, nothing forwarded.
  - credit >= PRICE_UNITS: go to VEND_WAIT. Credit max is 4 (₹10+₹10); the counter is 3 bits and never wraps.
  - port_req drops: with credit 0, release to IDLE. With credit > 0, go to REFUND.
  - Timer reaches TIMEOUT with credit > 0: go to REFUND. With credit 0 the timer does not run.
- VEND_WAIT:
  - No coins are forwarded; every coin on the owner gives port_reject.
  - On vm_out=1: next cycle, port_vend[g]=1 and port_change[g]=vm_change for one cycle. Credit clears, rr pointer becomes g+1 (mod N_PORTS), go to IDLE.
  - After VEND_WAIT cycles with no vm_out: fault pulses, go to REFUND.
- REFUND (one cycle):
  - refund_valid=1, refund_port=g, refund_amt=credit.
  - vm_clr=1 in the same cycle.
  - Credit clears, rr pointer becomes g+1, go to IDLE.
- vm_out in IDLE or COLLECT is spurious: ignored, not routed to any port.
- Coin and vm_out in the same cycle in VEND_WAIT: vend wins, the coin is rejected.
- grant is deasserted in the cycle after port_vend or refund_valid. A new grant needs at least one IDLE cycle.
- Reset mid-transaction: credit is lost with no refund pulse. The system integrator also resets the core.

Decomposition:
- vend_pkg holds:
  - coin codes COIN_NONE/5/10/INV;
  - coin-to-units function;
  - state enum (IDLE, COLLECT, VEND_WAIT, REFUND);
  - CREDIT_W=3.
- Sub-module vend_rr_arbiter:
  - inputs: req vector, pointer;
  - outputs: one-hot winner, winner index, any;
  - purely combinational.
- Pointer register and FSM stay in the top.

Test Plan:
- Port 0 req, coins 01,01,01; core pulses vm_out with change 00 -> vm_in mirrors each coin one cycle later. port_vend[0] pulses, port_change[0]=00, pointer=1.
- Port 2 coins 10,10; core pulses vm_out with change 01 -> credit reaches 4, port_vend[2] and port_change[2]=01.
- Ports 0,1,3 request together with pointer=1 -> grant order 1, 3, 0 over three completed transactions.
- Port 1 inserts 10, then idles 64 cycles -> refund_valid, refund_port=1, refund_amt=2, vm_clr pulse, back to IDLE.
- Port 0 inserts 01 then drops port_req -> immediate REFUND with refund_amt=1. Port 3 coin during port 0's grant -> port_reject[3], vm_in stays 00.
- Core never responds after 01,10 -> fault after 8 cycles, refund_amt=3, vm_clr. Reset asserted mid-COLLECT -> all outputs 0 immediately.
